// File: rtl/phy_rx_sync_monitor_pkg.sv
// Shared PCS definitions: sync-state encoding and the 8b10b K-code set.
`default_nettype none

package phy_rx_sync_monitor_pkg;

   typedef enum logic [1:0] {
      ST_LOS      = 2'd0,
      ST_ACQ      = 2'd1,
      ST_SYNC     = 2'd2,
      ST_SYNC_ERR = 2'd3
   } sync_state_t;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K23_7 = 8'hF7;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K30_7 = 8'hFE;
   localparam logic [7:0] K28_0 = 8'h1C;

   function automatic logic is_known_k(input logic [7:0] sym);
      return (sym == K28_5) || (sym == K23_7) || (sym == K27_7) ||
             (sym == K29_7) || (sym == K30_7) || (sym == K28_0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/phy_rx_word_classify.sv
// Combinational classifier: flags aligned commas and invalid PCS words.
`default_nettype none

module phy_rx_word_classify
   import phy_rx_sync_monitor_pkg::*;
(
   input  logic [15:0] data,
   input  logic [1:0]  k,
   input  logic        enc_err,
   output logic        comma,
   output logic        invalid
);

   logic bad_k_hi;
   logic bad_k_lo;
   logic split_comma;

   assign bad_k_hi    = k[1] && !is_known_k(data[15:8]);
   assign bad_k_lo    = k[0] && !is_known_k(data[7:0]);
   // A comma in the second symbol means the word boundary is off by one byte.
   assign split_comma = k[0] && (data[7:0] == K28_5);

   assign invalid = enc_err || split_comma || bad_k_hi || bad_k_lo;
   assign comma   = (k == 2'b10) && (data[15:8] == K28_5) && !enc_err;

endmodule

`default_nettype wire

// File: rtl/phy_rx_sync_monitor.sv
// Receive word-sync monitor: comma acquisition, error-credit loss-of-sync FSM,
// one-cycle registered datapath and saturating error / LOS counters.
`default_nettype none

module phy_rx_sync_monitor
   import phy_rx_sync_monitor_pkg::*;
#(
   parameter int g_acq_commas = 3,
   parameter int g_good_run   = 4,
   parameter int g_max_err    = 4
) (
   input  logic        clk_sys_i,
   input  logic        rst_n_i,
   input  logic        rx_valid_i,
   input  logic [15:0] rx_data_i,
   input  logic [1:0]  rx_k_i,
   input  logic        rx_enc_err_i,
   input  logic        cnt_clr_i,
   output logic [15:0] rx_data_o,
   output logic [1:0]  rx_k_o,
   output logic        rx_valid_o,
   output logic        link_up_o,
   output logic [1:0]  state_o,
   output logic        los_p1_o,
   output logic [15:0] err_cnt_o,
   output logic [7:0]  los_cnt_o
);

   localparam int CW  = $clog2(g_acq_commas + 1);
   localparam int CRW = $clog2(g_max_err + 1);
   localparam int RW  = $clog2(g_good_run + 1);
   localparam logic [CW-1:0]  ACQ_LAST = CW'(g_acq_commas - 1);
   localparam logic [CRW-1:0] CR_LAST  = CRW'(g_max_err - 1);
   localparam logic [RW-1:0]  RUN_LAST = RW'(g_good_run - 1);

   sync_state_t    state, state_nxt;
   logic [CW-1:0]  comma_cnt, comma_cnt_nxt;
   logic [CRW-1:0] credit, credit_nxt;
   logic [RW-1:0]  run, run_nxt;
   logic           los_evt;
   logic           is_comma;
   logic           is_invalid;
   logic           bad_word;

   phy_rx_word_classify u_classify (
      .data    (rx_data_i),
      .k       (rx_k_i),
      .enc_err (rx_enc_err_i),
      .comma   (is_comma),
      .invalid (is_invalid)
   );

   assign bad_word = rx_valid_i && is_invalid;

   always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
      if (rst_n_i) begin
         state     <= ST_LOS;
         comma_cnt <= '0;
         credit    <= '0;
         run       <= '0;
      end else begin
         state     <= state_nxt;
         comma_cnt <= comma_cnt_nxt;
         credit    <= credit_nxt;
         run       <= run_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      comma_cnt_nxt = comma_cnt;
      credit_nxt    = credit;
      run_nxt       = run;
      los_evt       = 1'b0;
      if (rx_valid_i) begin
         case (state)
            ST_LOS: begin
               if (is_comma) begin
                  if (ACQ_LAST == '0) begin
                     state_nxt = ST_SYNC;
                  end else begin
                     state_nxt     = ST_ACQ;
                     comma_cnt_nxt = CW'(1);
                  end
               end
            end
            ST_ACQ: begin
               if (is_invalid) begin
                  state_nxt     = ST_LOS;
                  comma_cnt_nxt = '0;
               end else if (is_comma) begin
                  if (comma_cnt == ACQ_LAST) begin
                     state_nxt     = ST_SYNC;
                     comma_cnt_nxt = '0;
                  end else begin
                     comma_cnt_nxt = comma_cnt + CW'(1);
                  end
               end
            end
            ST_SYNC: begin
               if (is_invalid) begin
                  state_nxt  = ST_SYNC_ERR;
                  credit_nxt = CRW'(1);
                  run_nxt    = '0;
               end
            end
            default: begin
               // An invalid word always wins over a pending credit decrement.
               if (is_invalid) begin
                  run_nxt = '0;
                  if (credit == CR_LAST) begin
                     state_nxt  = ST_LOS;
                     credit_nxt = '0;
                     los_evt    = 1'b1;
                  end else begin
                     credit_nxt = credit + CRW'(1);
                  end
               end else if (run == RUN_LAST) begin
                  run_nxt    = '0;
                  credit_nxt = credit - CRW'(1);
                  if (credit == CRW'(1)) begin
                     state_nxt = ST_SYNC;
                  end
               end else begin
                  run_nxt = run + RW'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
      if (rst_n_i) begin
         rx_data_o  <= '0;
         rx_k_o     <= '0;
         rx_valid_o <= 1'b0;
         los_p1_o   <= 1'b0;
         err_cnt_o  <= '0;
         los_cnt_o  <= '0;
      end else begin
         rx_data_o  <= rx_data_i;
         rx_k_o     <= rx_k_i;
         rx_valid_o <= rx_valid_i && (state_nxt == ST_SYNC || state_nxt == ST_SYNC_ERR);
         los_p1_o   <= los_evt;
         if (cnt_clr_i) begin
            err_cnt_o <= '0;
            los_cnt_o <= '0;
         end else begin
            if (bad_word && err_cnt_o != 16'hFFFF) begin
               err_cnt_o <= err_cnt_o + 16'd1;
            end
            if (los_evt && los_cnt_o != 8'hFF) begin
               los_cnt_o <= los_cnt_o + 8'd1;
            end
         end
      end
   end

   assign link_up_o = (state == ST_SYNC) || (state == ST_SYNC_ERR);
   assign state_o   = state;

endmodule

`default_nettype wire

// File: tb/tb_phy_rx_sync_monitor.sv
// Directed self-checking bench for phy_rx_sync_monitor.
`default_nettype none

module tb_phy_rx_sync_monitor;

   logic        clk_sys_i = 1'b0;
   logic        rst_n_i = 1'b1;
   logic        rx_valid_i = 1'b0;
   logic [15:0] rx_data_i = '0;
   logic [1:0]  rx_k_i = '0;
   logic        rx_enc_err_i = 1'b0;
   logic        cnt_clr_i = 1'b0;
   logic [15:0] rx_data_o;
   logic [1:0]  rx_k_o;
   logic        rx_valid_o;
   logic        link_up_o;
   logic [1:0]  state_o;
   logic        los_p1_o;
   logic [15:0] err_cnt_o;
   logic [7:0]  los_cnt_o;

   int n_checks = 0;
   int n_pass   = 0;

   phy_rx_sync_monitor dut (
      .clk_sys_i    (clk_sys_i),
      .rst_n_i      (rst_n_i),
      .rx_valid_i   (rx_valid_i),
      .rx_data_i    (rx_data_i),
      .rx_k_i       (rx_k_i),
      .rx_enc_err_i (rx_enc_err_i),
      .cnt_clr_i    (cnt_clr_i),
      .rx_data_o    (rx_data_o),
      .rx_k_o       (rx_k_o),
      .rx_valid_o   (rx_valid_o),
      .link_up_o    (link_up_o),
      .state_o      (state_o),
      .los_p1_o     (los_p1_o),
      .err_cnt_o    (err_cnt_o),
      .los_cnt_o    (los_cnt_o)
   );

   always #5 clk_sys_i = ~clk_sys_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Apply one word for one clock, then settle just past the edge.
   task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] k,
                        input logic e, input logic clr);
      rx_valid_i   = v;
      rx_data_i    = d;
      rx_k_i       = k;
      rx_enc_err_i = e;
      cnt_clr_i    = clr;
      @(posedge clk_sys_i);
      #1;
   endtask

   task automatic comma();
      drive(1'b1, 16'hBC50, 2'b10, 1'b0, 1'b0);
   endtask

   task automatic gap();
      drive(1'b0, 16'hBC50, 2'b10, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk_sys_i);
      #1;
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_link", 32'(link_up_o), 32'd0);
      check("rst_valid", 32'(rx_valid_o), 32'd0);
      check("rst_los_p1", 32'(los_p1_o), 32'd0);
      check("rst_err_cnt", 32'(err_cnt_o), 32'd0);
      check("rst_los_cnt", 32'(los_cnt_o), 32'd0);
      rst_n_i = 1'b0;

      // Acquisition from three aligned commas
      comma(); check("acq1_state", 32'(state_o), 32'd1);
      check("acq1_valid", 32'(rx_valid_o), 32'd0);
      comma(); check("acq2_state", 32'(state_o), 32'd1);
      check("acq2_link", 32'(link_up_o), 32'd0);
      comma(); check("acq3_state", 32'(state_o), 32'd2);
      check("acq3_link", 32'(link_up_o), 32'd1);
      check("acq3_fwd_valid", 32'(rx_valid_o), 32'd1);
      check("acq3_fwd_data", 32'(rx_data_o), 32'hBC50);
      check("acq3_fwd_k", 32'(rx_k_o), 32'h2);

      // Known K codes are valid in SYNC
      drive(1'b1, 16'hF7FB, 2'b11, 1'b0, 1'b0);
      check("kcode1_state", 32'(state_o), 32'd2);
      check("kcode1_data", 32'(rx_data_o), 32'hF7FB);
      drive(1'b1, 16'hFDFE, 2'b11, 1'b0, 1'b0);
      check("kcode2_state", 32'(state_o), 32'd2);
      drive(1'b1, 16'h1C00, 2'b10, 1'b0, 1'b0);
      check("kcode3_state", 32'(state_o), 32'd2);
      check("kcode_err_cnt", 32'(err_cnt_o), 32'd0);

      // Continuous misaligned commas: four invalid words drop sync
      drive(1'b1, 16'h00BC, 2'b01, 1'b0, 1'b0);
      check("mis1_state", 32'(state_o), 32'd3);
      check("mis1_link", 32'(link_up_o), 32'd1);
      drive(1'b1, 16'h00BC, 2'b01, 1'b0, 1'b0);
      drive(1'b1, 16'h00BC, 2'b01, 1'b0, 1'b0);
      check("mis3_state", 32'(state_o), 32'd3);
      check("mis3_los_p1", 32'(los_p1_o), 32'd0);
      drive(1'b1, 16'h00BC, 2'b01, 1'b0, 1'b0);
      check("mis4_state", 32'(state_o), 32'd0);
      check("mis4_link", 32'(link_up_o), 32'd0);
      check("mis4_los_p1", 32'(los_p1_o), 32'd1);
      check("mis4_err_cnt", 32'(err_cnt_o), 32'd4);
      gap();
      check("mis_post_los_p1", 32'(los_p1_o), 32'd0);
      check("mis_los_cnt", 32'(los_cnt_o), 32'd1);

      // Counter clear, then valid data in LOS is not forwarded
      drive(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1);
      check("clr_err_cnt", 32'(err_cnt_o), 32'd0);
      check("clr_los_cnt", 32'(los_cnt_o), 32'd0);
      drive(1'b1, 16'h1234, 2'b00, 1'b0, 1'b0);
      check("los_gate_valid", 32'(rx_valid_o), 32'd0);
      check("los_hold_state", 32'(state_o), 32'd0);

      // One error then four good words returns to SYNC
      comma(); comma(); comma();
      check("reacq_state", 32'(state_o), 32'd2);
      drive(1'b1, 16'h1234, 2'b00, 1'b1, 1'b0);
      check("rec_err_state", 32'(state_o), 32'd3);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h1234, 2'b00, 1'b0, 1'b0);
         check("rec_run_state", 32'(state_o), 32'd3);
         check("rec_run_link", 32'(link_up_o), 32'd1);
      end
      drive(1'b1, 16'h1234, 2'b00, 1'b0, 1'b0);
      check("rec_done_state", 32'(state_o), 32'd2);
      check("rec_err_cnt", 32'(err_cnt_o), 32'd1);

      // Invalid word on the would-be decrement: credit climbs to 2 instead
      drive(1'b1, 16'h1234, 2'b00, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 16'h1234, 2'b00, 1'b0, 1'b0);
      gap();
      drive(1'b1, 16'h1234, 2'b00, 1'b1, 1'b0);
      check("prec_state", 32'(state_o), 32'd3);
      for (int i = 0; i < 7; i++) drive(1'b1, 16'h1234, 2'b00, 1'b0, 1'b0);
      check("prec_7good_state", 32'(state_o), 32'd3);
      drive(1'b1, 16'h1234, 2'b00, 1'b0, 1'b0);
      check("prec_8good_state", 32'(state_o), 32'd2);

      // Asynchronous reset mid-operation while in SYNC_ERR
      drive(1'b1, 16'h1234, 2'b00, 1'b1, 1'b0);
      check("arst_pre_state", 32'(state_o), 32'd3);
      #2 rst_n_i = 1'b1;
      #1;
      check("arst_state", 32'(state_o), 32'd0);
      check("arst_link", 32'(link_up_o), 32'd0);
      check("arst_err_cnt", 32'(err_cnt_o), 32'd0);
      #1 rst_n_i = 1'b0;
      comma();
      check("arst_first_comma", 32'(state_o), 32'd1);
      check("arst_no_los_p1", 32'(los_p1_o), 32'd0);

      // Decode error during acquisition restarts the comma count
      comma();
      drive(1'b1, 16'hBC50, 2'b10, 1'b1, 1'b0);
      check("acqerr_state", 32'(state_o), 32'd0);
      check("acqerr_err_cnt", 32'(err_cnt_o), 32'd1);
      comma(); comma();
      check("acqerr_2c_link", 32'(link_up_o), 32'd0);
      comma();
      check("acqerr_3c_link", 32'(link_up_o), 32'd1);

      // Unknown K byte drops sync; then acquisition with valid gaps
      for (int i = 0; i < 4; i++) drive(1'b1, 16'h1234, 2'b10, 1'b0, 1'b0);
      check("badk_state", 32'(state_o), 32'd0);
      check("badk_los_p1", 32'(los_p1_o), 32'd1);
      check("badk_los_cnt", 32'(los_cnt_o), 32'd1);
      comma(); check("gap_c1", 32'(state_o), 32'd1);
      gap();   check("gap_g1", 32'(state_o), 32'd1);
      comma(); check("gap_c2", 32'(state_o), 32'd1);
      gap();   check("gap_g2", 32'(state_o), 32'd1);
      gap();   check("gap_g3", 32'(state_o), 32'd1);
      check("gap_g3_valid", 32'(rx_valid_o), 32'd0);
      comma(); check("gap_c3", 32'(state_o), 32'd2);

      // Saturation of the error counter and clear-over-increment priority
      drive(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 65535; i++) begin
         rx_valid_i   = 1'b1;
         rx_data_i    = 16'h00BC;
         rx_k_i       = 2'b01;
         rx_enc_err_i = 1'b0;
         cnt_clr_i    = 1'b0;
         @(posedge clk_sys_i);
      end
      #1;
      check("sat_reach", 32'(err_cnt_o), 32'hFFFF);
      drive(1'b1, 16'h00BC, 2'b01, 1'b0, 1'b0);
      check("sat_hold", 32'(err_cnt_o), 32'hFFFF);
      drive(1'b1, 16'h00BC, 2'b01, 1'b0, 1'b1);
      check("clr_prio_err", 32'(err_cnt_o), 32'd0);
      check("clr_prio_los", 32'(los_cnt_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/phy_rx_sync_monitor.md
PHY_RX_SYNC_MONITOR -- requirements
Module: phy_rx_sync_monitor

Interface
REQ-001 Parameter g_acq_commas, default 3: number of consecutive aligned commas needed to declare sync.
REQ-002 Parameter g_good_run, default 4: number of consecutive valid words that removes one error credit.
REQ-003 Parameter g_max_err, default 4: number of error credits that forces loss of sync.
REQ-004 clk_sys_i  in  1  system clock; all logic is synchronous to its rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous, active-high.
REQ-006 rx_valid_i  in  1  qualifies rx_data_i, rx_k_i and rx_enc_err_i in the current cycle.
REQ-007 rx_data_i  in  16  decoded PCS word; [15:8] is the first symbol.
REQ-008 rx_k_i  in  2  K flags; [1] applies to [15:8] and [0] applies to [7:0].
REQ-009 rx_enc_err_i  in  1  8b10b decode error for the word.
REQ-010 cnt_clr_i  in  1  synchronous clear of both counters.
REQ-011 rx_data_o  out  16  registered copy of rx_data_i.
REQ-012 rx_k_o  out  2  registered copy of rx_k_i.
REQ-013 rx_valid_o  out  1  registered rx_valid_i, gated by the sync state.
REQ-014 link_up_o  out  1  high while the state is SYNC or SYNC_ERR.
REQ-015 state_o  out  2  encoding: LOS=0, ACQ=1, SYNC=2, SYNC_ERR=3.
REQ-016 los_p1_o  out  1  one-cycle pulse on each transition into LOS from SYNC_ERR.
REQ-017 err_cnt_o  out  16  saturating count of invalid words.
REQ-018 los_cnt_o  out  8  saturating count of loss-of-sync events.

Function
REQ-019 Aligned comma: rx_k_i=2'b10, rx_data_i[15:8]=0xBC, rx_enc_err_i=0.
REQ-020 Invalid word is any of the following:
- rx_enc_err_i=1.
- rx_k_i[0]=1 with rx_data_i[7:0]=0xBC (misaligned comma, e.g. 0x00BC/2'b01).
- Any K byte outside {0xBC,0xF7,0xFB,0xFD,0xFE,0x1C}.
REQ-021 The monitor evaluates words only when rx_valid_i=1; cycles with rx_valid_i=0 change no state, run count or credit.
REQ-022 LOS: an aligned comma moves the FSM to ACQ with comma count 1; anything else stays in LOS.
REQ-023 ACQ:
- Aligned comma: increment the comma count; reaching g_acq_commas moves the FSM to SYNC.
- Invalid word: return to LOS with the comma count cleared.
- Valid non-comma word: hold the count.
REQ-024 SYNC: an invalid word moves the FSM to SYNC_ERR with credit=1 and run=0.
REQ-025 SYNC_ERR, on an invalid word:
- Credit increments and run clears.
- If credit reaches g_max_err, the FSM goes to LOS and los_p1_o pulses in the following cycle.
REQ-026 SYNC_ERR, on a valid word:
- Run increments.
- When run reaches g_good_run, credit decrements and run clears.
- When credit reaches 0, the FSM returns to SYNC.
REQ-027 If an invalid word and a credit decrement coincide, the invalid word takes precedence: no decrement occurs.
REQ-028 Datapath latency is one cycle.
- rx_valid_o = registered rx_valid_i AND the post-update state is SYNC or SYNC_ERR.
- The word that completes acquisition is therefore forwarded.
REQ-029 err_cnt_o increments by 1 for each valid-qualified invalid word in any state and holds at 0xFFFF.
REQ-030 los_cnt_o increments with each los_p1_o and holds at 0xFF.
REQ-031 cnt_clr_i clears both counters on the next edge and takes priority over a simultaneous increment.

Reset
REQ-032 While rst_n_i=1, every output and register is asynchronously 0 and the state is LOS.
REQ-033 Reset asserted mid-operation discards the comma count, credit and run; link_up_o falls immediately; no los_p1_o is generated.
REQ-034 After reset release, the first aligned comma is accepted on the first clk_sys_i rising edge.

Structure
REQ-035 The state encoding constants and the K-code constants (0xBC, 0xF7, 0xFB, 0xFD, 0xFE, 0x1C) belong in the shared PCS package.
REQ-036 The valid/invalid/comma word classifier is one combinational sub-module, phy_rx_word_classify; the FSM and the counters reside in the top module.

Verification
REQ-037 Reset, then three 0xBC50/2'b10 words -> state_o is 1, 1, 2; link_up_o=1 one cycle after the third word.
REQ-038 In SYNC, drive 0x00BC/2'b01 continuously -> SYNC_ERR after 1 word; LOS after the 4th invalid word; los_p1_o is one pulse; los_cnt_o=1; err_cnt_o=4.
REQ-039 In SYNC, drive 1 error then 4 valid 0x1234/2'b00 words -> SYNC_ERR then back to SYNC; link_up_o never drops; err_cnt_o=1.
REQ-040 In ACQ after 2 commas, drive 1 word with rx_enc_err_i=1 -> LOS; a further 3 commas are required before link_up_o rises.
REQ-041 Force err_cnt_o to 0xFFFF, then drive an invalid word -> the count stays 0xFFFF; cnt_clr_i in the same cycle as an increment -> err_cnt_o reads 0.
REQ-042 Interleave rx_valid_i=0 cycles within comma acquisition -> the number of cycles to SYNC increases by the gap count; no state change occurs during the gaps.
